// File: rtl/data_mem_resp.sv
// data_mem_resp: responder side of the data-memory request/ack handshake, backed by
// a resettable register-file memory. Define DATA_MEM_ZERO_REG_EN to hard-wire word 0 to zero.
module data_mem_resp #(
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_data_mem,
  input  logic [AW-1:0] adr_data,
  output logic [DW-1:0] data,
  output logic          out_data_mem,
  input  logic          write_data,
  input  logic [AW-1:0] adr_data_write,
  input  logic [DW-1:0] data_write,
  output logic          out_write_mem,
  output logic          busy
);

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATA_MEM_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_ACK, WR_WAIT, WR_ACK} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_adr, w_adr;
  logic [DW-1:0] r_wdata, w_wdata;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_in_range;
  logic          w_zero_hit;
  logic          w_do_write;
  logic [DW-1:0] w_rd_word;

  // Next state; in IDLE the live inputs are selected so a latency-1 access uses them directly
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adr       = r_adr;
    w_wdata     = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (write_data) begin
          w_adr       = adr_data_write;
          w_wdata     = data_write;
          w_cnt_nxt   = CW'(WR_LAT - 1);
          w_state_nxt = (WR_LAT == 1) ? WR_ACK : WR_WAIT;
        end else if (in_data_mem) begin
          w_adr       = adr_data;
          w_cnt_nxt   = CW'(RD_LAT - 1);
          w_state_nxt = (RD_LAT == 1) ? RD_ACK : RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = RD_ACK;
      end
      WR_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = WR_ACK;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_range = (32'(w_adr) < DEPTH);
  assign w_zero_hit = ZERO_REG && (w_adr == '0);
  assign w_do_write = (w_state_nxt == WR_ACK) && w_in_range && !w_zero_hit;
  assign w_rd_word  = (w_in_range && !w_zero_hit) ? r_mem[IW'(w_adr)] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_adr         <= '0;
      r_wdata       <= '0;
      data          <= '0;
      out_data_mem  <= 1'b0;
      out_write_mem <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_adr         <= w_adr;
      r_wdata       <= w_wdata;
      out_data_mem  <= (w_state_nxt == RD_ACK);
      out_write_mem <= (w_state_nxt == WR_ACK);
      busy          <= (w_state_nxt != IDLE);
      if (w_state_nxt == RD_ACK) data <= w_rd_word;
    end
  end

  // Storage; a reset mid-write wins over the pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[IW'(i)] <= '0;
    end else if (w_do_write) begin
      r_mem[IW'(w_adr)] <= w_wdata;
    end
  end

endmodule
